div_10: RTL and testbench

Unsigned 32-bit divide-by-constant-10 unit: for every accepted operand it produces the exact quotient `num / 10` and remainder `num % 10`. It is a fully pipelined datapath block with one new operand accepted per clock and a fixed latency. It sits beside the FPU's integer/format-conversion logic, where it serves binary-to-decimal conversion and similar constant-divisor needs.

---
 rtl/div_10.sv | 36 +++
 tb/tb_div_10.sv | 101 ++++++++++
 2 files changed

// File: rtl/div_10.sv
// div_10: two-stage pipelined unsigned 32-bit divide by 10 (quotient and remainder).
module div_10 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] num,
  output logic        out_valid,
  output logic [31:0] q,
  output logic [31:0] r
);
  logic        v1;
  logic [31:0] num1, qe1, qe, r_raw;
  logic        fix;
  always_comb begin
    qe = 32'(({32'd0, num} * 64'hCCCC_CCCD) >> 35);
    r_raw = num1 - ((qe1 << 3) + (qe1 << 1));
    fix = r_raw >= 32'd10;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      num1 <= '0;
      qe1 <= '0;
      out_valid <= 1'b0;
      q <= '0;
      r <= '0;
    end else begin
      v1 <= in_valid;
      num1 <= num;
      qe1 <= qe;
      out_valid <= v1;
      q <= fix ? qe1 + 32'd1 : qe1;
      r <= fix ? r_raw - 32'd10 : r_raw;
    end
  end
endmodule

// File: tb/tb_div_10.sv
// tb_div_10: table vectors plus streaming, gapped and reset sequences checked via a result queue.
module tb_div_10;
  typedef struct {
    logic [31:0] num;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] num = '0;
  logic        out_valid;
  logic [31:0] q, r;
  logic        ev1 = 1'b0, ev2 = 1'b0;
  vec_t        sb[$];
  vec_t        tbl[7];
  int          n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  div_10 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .num(num),
    .out_valid(out_valid), .q(q), .r(r)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic tick(input logic v, input logic [31:0] n, input logic [31:0] eq,
                      input logic [31:0] er, input logic rs);
    vec_t e;
    vec_t f;
    in_valid = v;
    num = n;
    rst = rs;
    @(posedge clk);
    ev2 = rs ? 1'b0 : ev1;
    ev1 = rs ? 1'b0 : v;
    if (rs) sb.delete();
    else if (v) begin
      e.num = n; e.q = eq; e.r = er;
      sb.push_back(e);
    end
    #1;
    check("out_valid", {31'd0, out_valid}, {31'd0, ev2});
    if (rs) begin
      check("reset_q", q, 32'd0);
      check("reset_r", r, 32'd0);
    end else if (ev2 && sb.size() > 0) begin
      f = sb.pop_front();
      check($sformatf("q(num=%0d)", f.num), q, f.q);
      check($sformatf("r(num=%0d)", f.num), r, f.r);
    end
  endtask

  task automatic rand_tick(input logic v);
    logic [31:0] hi, lo, n;
    hi = $urandom_range(0, 9);
    lo = $urandom();
    n = {hi[3:0], lo[27:0]};
    tick(v, n, n / 10, n % 10, 1'b0);
  endtask

  initial begin
    tbl[0] = '{32'd0,          32'd0,         32'd0};
    tbl[1] = '{32'd9,          32'd0,         32'd9};
    tbl[2] = '{32'd10,         32'd1,         32'd0};
    tbl[3] = '{32'd99,         32'd9,         32'd9};
    tbl[4] = '{32'hFFFF_FFFF,  32'd429496729, 32'd5};
    tbl[5] = '{32'h9FFF_FFFF,  32'd268435455, 32'd9};
    tbl[6] = '{32'hA000_0000,  32'd268435456, 32'd0};

    tick(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
    tick(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);

    for (int i = 0; i < 7; i++) tick(1'b1, tbl[i].num, tbl[i].q, tbl[i].r, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 32'd0, 32'd0, 32'd0, 1'b0);

    for (int i = 0; i < 50; i++) rand_tick(1'b1);
    for (int i = 0; i < 3; i++) rand_tick(1'b0);

    for (int i = 0; i < 12; i++) rand_tick(i[0] == 1'b0);
    for (int i = 0; i < 3; i++) rand_tick(1'b0);

    tick(1'b1, 32'd1234, 32'd123, 32'd4, 1'b0);
    tick(1'b1, 32'd5678, 32'd567, 32'd8, 1'b0);
    tick(1'b1, 32'd4321, 32'd432, 32'd1, 1'b1);
    tick(1'b1, 32'd87654321, 32'd8765432, 32'd1, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, 32'd0, 32'd0, 32'd0, 1'b0);

    check("drain", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
